// File: rtl/bus_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_mux_arbiter_if
// Description : Request/grant handshake and shared-bus signals between two
//               requesters and the round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_mux_arbiter_if #(
  parameter int NR_OF_BITS = 32
);
  // Requester side
  logic                  req_0;
  logic                  req_1;
  logic                  last_0;
  logic                  last_1;
  logic [NR_OF_BITS-1:0] data_0;
  logic [NR_OF_BITS-1:0] data_1;

  // Arbiter side
  logic                  grant_0;
  logic                  grant_1;
  logic                  mux_enable;
  logic                  mux_sel;
  logic [NR_OF_BITS-1:0] mux_out;
  logic                  out_valid;

  // Requesters drive the handshake and observe the bus
  modport master (
    output req_0, req_1, last_0, last_1, data_0, data_1,
    input  grant_0, grant_1, mux_enable, mux_sel, mux_out, out_valid
  );

  // The arbiter observes the requesters and drives the bus controls
  modport slave (
    input  req_0, req_1, last_0, last_1, data_0, data_1,
    output grant_0, grant_1, mux_enable, mux_sel, mux_out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/bus_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_mux_arbiter
// Description : Two-requester round-robin arbiter owning the Enable/Sel
//               controls of a shared 2:1 mux, with bounded hold time and a
//               registered copy of the selected data word.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mux_arbiter #(
  parameter int NR_OF_BITS = 32,
  parameter int MAX_HOLD   = 8,   // >= 2
  parameter int CNT_BITS   = 3    // 2**CNT_BITS >= MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_mux_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Last count value of a grant; the owner is preempted here if contended
  localparam logic [CNT_BITS-1:0] C_HOLD_LAST = CNT_BITS'(MAX_HOLD - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rr_last;       // side that most recently released
  logic                  w_rr_last_next;
  logic [CNT_BITS-1:0]   r_hold_cnt;
  logic                  w_hold_expired;
  logic                  w_enable;
  logic                  w_sel;
  logic                  w_req_owner;
  logic [NR_OF_BITS-1:0] r_mux_out;
  logic                  r_out_valid;

  // Preemption uses the pre-increment count, giving exactly MAX_HOLD cycles
  assign w_hold_expired = (r_hold_cnt == C_HOLD_LAST);

  // Controls decode straight from the state register, so they are glitch-free
  assign w_enable    = (r_state != IDLE);
  assign w_sel       = (r_state == GRANT1);
  assign w_req_owner = w_sel ? bus.req_1 : bus.req_0;

  assign bus.grant_0    = (r_state == GRANT0);
  assign bus.grant_1    = (r_state == GRANT1);
  assign bus.mux_enable = w_enable;
  assign bus.mux_sel    = w_sel;
  assign bus.mux_out    = r_mux_out;
  assign bus.out_valid  = r_out_valid;

  // State, round-robin pointer and hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_last  <= 1'b1;   // requester 0 wins the first tie
      r_hold_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rr_last <= w_rr_last_next;
      if (w_state_next != r_state) begin
        r_hold_cnt <= '0;
      end else if (r_state != IDLE && !w_hold_expired) begin
        // Saturates rather than wraps so an uncontested owner keeps the bus
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Next-state arbitration: tie-break in IDLE, release handling in GRANTx
  always_comb begin
    w_state_next   = r_state;
    w_rr_last_next = r_rr_last;
    case (r_state)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          w_state_next = r_rr_last ? GRANT0 : GRANT1;
        end else if (bus.req_0) begin
          w_state_next = GRANT0;
        end else if (bus.req_1) begin
          w_state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!bus.req_0 || bus.last_0 || (w_hold_expired && bus.req_1)) begin
          w_rr_last_next = 1'b0;
          // Hand over directly when the other side waits: no idle bubble
          w_state_next   = bus.req_1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!bus.req_1 || bus.last_1 || (w_hold_expired && bus.req_0)) begin
          w_rr_last_next = 1'b1;
          w_state_next   = bus.req_0 ? GRANT0 : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Registered shared-bus data: one cycle behind the mux controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_mux_out   <= w_enable ? (w_sel ? bus.data_1 : bus.data_0) : '0;
      r_out_valid <= w_enable & w_req_owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mux_arbiter
// Description : Directed self-checking bench for bus_mux_arbiter with an
//               expected-result queue filled as each step is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mux_arbiter;
  localparam int NB = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bus_mux_arbiter_if #(.NR_OF_BITS(NB)) bus ();

  bus_mux_arbiter #(
    .NR_OF_BITS (NB),
    .MAX_HOLD   (8),
    .CNT_BITS   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          en;
    logic          sel;
    logic          valid;
    logic [NB-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic eg0    = 1'b0;   // expected grant state currently visible
  logic eg1    = 1'b0;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/grant_0"},    NB'(bus.grant_0),    '0);
    chk({tag, "/grant_1"},    NB'(bus.grant_1),    '0);
    chk({tag, "/mux_enable"}, NB'(bus.mux_enable), '0);
    chk({tag, "/mux_sel"},    NB'(bus.mux_sel),    '0);
    chk({tag, "/mux_out"},    bus.mux_out,         '0);
    chk({tag, "/out_valid"},  NB'(bus.out_valid),  '0);
  endtask

  // One clock step: drive inputs, queue the expected result, sample after edge
  task automatic step(input logic r0, input logic r1, input logic l0, input logic l1,
                      input logic [NB-1:0] d0, input logic [NB-1:0] d1,
                      input logic ng0, input logic ng1, input string tag);
    exp_t e;
    exp_t got;
    bus.req_0  = r0;
    bus.req_1  = r1;
    bus.last_0 = l0;
    bus.last_1 = l1;
    bus.data_0 = d0;
    bus.data_1 = d1;
    e.g0    = ng0;
    e.g1    = ng1;
    e.en    = ng0 | ng1;
    e.sel   = ng1;
    e.data  = eg1 ? d1 : (eg0 ? d0 : '0);
    e.valid = (eg0 & r0) | (eg1 & r1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "/grant_0"},    NB'(bus.grant_0),    NB'(got.g0));
    chk({tag, "/grant_1"},    NB'(bus.grant_1),    NB'(got.g1));
    chk({tag, "/mux_enable"}, NB'(bus.mux_enable), NB'(got.en));
    chk({tag, "/mux_sel"},    NB'(bus.mux_sel),    NB'(got.sel));
    chk({tag, "/mux_out"},    bus.mux_out,         got.data);
    chk({tag, "/out_valid"},  NB'(bus.out_valid),  NB'(got.valid));
    chk({tag, "/onehot"},     NB'(bus.grant_0 & bus.grant_1), '0);
    eg0 = ng0;
    eg1 = ng1;
  endtask

  // Reset pulse placed between clock edges so outputs must clear asynchronously
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    bus.req_0  = 1'b0;
    bus.req_1  = 1'b0;
    bus.last_0 = 1'b0;
    bus.last_1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    eg0 = 1'b0;
    eg1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_0  = 1'b0;
    bus.req_1  = 1'b0;
    bus.last_0 = 1'b0;
    bus.last_1 = 1'b0;
    bus.data_0 = '0;
    bus.data_1 = '0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester with last on third sampled cycle
    step(1, 0, 0, 0, 32'hA5A5_0001, 32'h5A5A_0001, 1, 0, "t1_req");
    step(1, 0, 0, 0, 32'hA5A5_0002, 32'h5A5A_0002, 1, 0, "t1_hold");
    step(1, 0, 1, 0, 32'hA5A5_0003, 32'h5A5A_0003, 0, 0, "t1_last");
    step(0, 0, 0, 0, 32'hA5A5_0004, 32'h5A5A_0004, 0, 0, "t1_idle");

    // Data path: DEADBEEF appears one cycle later, then zero in IDLE
    step(1, 0, 0, 0, 32'h0000_0000, 32'h0000_1234, 1, 0, "t5_req");
    step(1, 0, 1, 0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, "t5_beat");
    step(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, "t5_idle");

    // Requester 0 released last, so a tie now goes to requester 1
    step(1, 1, 0, 0, $urandom(), $urandom(), 0, 1, "rr_tie1");
    step(0, 0, 0, 0, $urandom(), $urandom(), 0, 0, "rr_drop");

    do_reset("sync_reset");

    // Tie after reset: requester 0 first, then handover with no gap
    step(1, 1, 0, 0, $urandom(), $urandom(), 1, 0, "t2_tie");
    step(1, 1, 0, 0, $urandom(), $urandom(), 1, 0, "t2_hold");
    step(1, 1, 1, 0, $urandom(), $urandom(), 0, 1, "t2_last");
    step(0, 1, 0, 0, $urandom(), $urandom(), 0, 1, "t2_own1");
    step(0, 0, 0, 0, $urandom(), $urandom(), 0, 0, "t2_idle");

    // Continuous contention: ownership alternates every 8 cycles
    for (int k = 0; k < 32; k++) begin
      step(1, 1, 0, 0, $urandom(), $urandom(),
           ((k / 8) % 2) == 0, ((k / 8) % 2) == 1, "t3_rr");
    end
    step(0, 0, 0, 0, $urandom(), $urandom(), 0, 0, "t3_drop");

    // Uncontested owner holds for 20 cycles; counter must not wrap
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, 0, $urandom(), $urandom(), 0, 1, "t4_hold");
    end
    step(1, 1, 0, 0, $urandom(), $urandom(), 1, 0, "t4_sat");
    step(1, 0, 0, 1, $urandom(), $urandom(), 1, 0, "t4_ign_last1");
    step(0, 1, 0, 0, $urandom(), $urandom(), 0, 1, "t4_swap");
    step(0, 1, 0, 1, $urandom(), $urandom(), 0, 0, "t4_last1");

    // Asynchronous reset in the middle of a GRANT1 tenure
    step(0, 1, 0, 0, 32'hCAFE_0001, 32'hBEEF_0001, 0, 1, "t6_req");
    step(0, 1, 0, 0, 32'hCAFE_0002, 32'hBEEF_0002, 0, 1, "t6_hold");
    do_reset("t6_async");
    step(1, 1, 0, 0, $urandom(), $urandom(), 1, 0, "t6_tie");
    step(0, 0, 0, 0, $urandom(), $urandom(), 0, 0, "t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
